ldpc_enc_ctrl: RTL

Frame sequencer for the 360-parallel LDPC parity encoder. It accepts a serial information-bit stream from the upstream scrambler/BCH stage through a valid/ready handshake and drives the encoder's `din_valid`/`din`/`counter` inputs. It then sweeps the parity readout (`out_addr`, `data_valid_check`) and merges systematic and parity bits into one registered codeword stream for the downstream interleaver. It also produces the encoder's per-frame synchronous clear.

---
 rtl/ldpc_enc_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ldpc_enc_ctrl.sv
// Frame sequencer for the 360-parallel LDPC parity encoder: feeds info bits,
// sweeps the parity readout, merges both into one registered codeword stream
// and issues the encoder's per-frame synchronous clear.
module ldpc_enc_ctrl #(
  parameter int unsigned K       = 4320,
  parameter int unsigned P       = 360,
  parameter int unsigned CLR_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic        s_data,
  output logic        s_ready,
  output logic        enc_clr_n,
  output logic        enc_din_valid,
  output logic        enc_din,
  output logic [12:0] enc_counter,
  output logic [8:0]  enc_out_addr,
  output logic        enc_data_valid_check,
  input  logic        enc_dout,
  output logic        m_valid,
  output logic        m_data,
  output logic        m_last
);

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CYC_W  = 2;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_INFO   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]    enc_counter_q, enc_counter_d;
  logic [ADDR_W-1:0]   enc_out_addr_q, enc_out_addr_d;
  logic                dvc_q, dvc_d;
  logic                rd_q, rd_d;
  logic                rd_last_q, rd_last_d;
  logic                s_ready_q, s_ready_d;
  logic                enc_clr_n_q, enc_clr_n_d;
  logic                m_valid_q, m_valid_d;
  logic                m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic                accept;
  logic                last_info;

  // Handshake: a bit is consumed only while the INFO ready flop is set
  assign accept    = s_valid & s_ready_q;
  assign last_info = (enc_counter_q == CNT_W'(K - 1));

  assign enc_din_valid        = accept;
  assign enc_din              = s_data;
  assign s_ready              = s_ready_q;
  assign enc_clr_n            = enc_clr_n_q;
  assign enc_counter          = enc_counter_q;
  assign enc_out_addr         = enc_out_addr_q;
  assign enc_data_valid_check = dvc_q;
  assign m_valid              = m_valid_q;
  assign m_data               = m_data_q;
  assign m_last               = m_last_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR:  if (cyc_cnt_q == CYC_W'(CLR_CYC - 1)) state_d = ST_INFO;
      ST_INFO:   if (accept && last_info)               state_d = ST_PARITY;
      ST_PARITY: if (enc_out_addr_q == '0)               state_d = ST_DRAIN;
      ST_DRAIN:  if (cyc_cnt_q == CYC_W'(1))             state_d = ST_CLEAR;
      default:                                           state_d = ST_CLEAR;
    endcase
  end

  // Output / datapath next values; all outputs are registered from these
  always_comb begin
    cyc_cnt_d      = '0;
    enc_counter_d  = '0;
    enc_out_addr_d = ADDR_W'(P - 1);
    dvc_d          = (state_d == ST_PARITY);
    rd_d           = dvc_q;
    rd_last_d      = dvc_q && (enc_out_addr_q == '0);
    s_ready_d      = (state_d == ST_INFO);
    enc_clr_n_d    = (state_d != ST_CLEAR);
    m_valid_d      = 1'b0;
    m_data_d       = 1'b0;
    m_last_d       = 1'b0;

    // Dwell counter shared by CLEAR and DRAIN, restarted on every state change
    if (((state_q == ST_CLEAR) || (state_q == ST_DRAIN)) && (state_d == state_q))
      cyc_cnt_d = cyc_cnt_q + CYC_W'(1);

    // Info index advances on accepts only, wrapping to 0 after the last bit
    if (state_q == ST_INFO) begin
      enc_counter_d = enc_counter_q;
      if (accept) enc_counter_d = last_info ? '0 : enc_counter_q + CNT_W'(1);
    end

    // Parity address sweeps P-1 down to 0, parked at P-1 otherwise
    if ((state_q == ST_PARITY) && (state_d == ST_PARITY))
      enc_out_addr_d = enc_out_addr_q - ADDR_W'(1);

    // Merge: systematic bits one cycle after accept, parity one cycle after enc_dout
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data;
    end else if (rd_q) begin
      m_valid_d = 1'b1;
      m_data_d  = enc_dout;
      m_last_d  = rd_last_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q      <= '0;
      enc_counter_q  <= '0;
      enc_out_addr_q <= ADDR_W'(P - 1);
      dvc_q          <= 1'b0;
      rd_q           <= 1'b0;
      rd_last_q      <= 1'b0;
      s_ready_q      <= 1'b0;
      enc_clr_n_q    <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= 1'b0;
      m_last_q       <= 1'b0;
    end else begin
      cyc_cnt_q      <= cyc_cnt_d;
      enc_counter_q  <= enc_counter_d;
      enc_out_addr_q <= enc_out_addr_d;
      dvc_q          <= dvc_d;
      rd_q           <= rd_d;
      rd_last_q      <= rd_last_d;
      s_ready_q      <= s_ready_d;
      enc_clr_n_q    <= enc_clr_n_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
    end
  end

endmodule
